// File: rtl/apb_master_bridge.sv
// APB master bridge: one requester, two APB slaves selected by the request address MSB.
// Define APB_TIMEOUT_EN to bound the ACCESS-phase wait to TIMEOUT_CYCLES cycles.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  transfer,
    input  logic                  READ_WRITE,
    input  logic [ADDR_WIDTH:0]   apb_write_paddr,
    input  logic [ADDR_WIDTH:0]   apb_read_paddr,
    input  logic [DATA_WIDTH-1:0] apb_write_data,
    output logic [DATA_WIDTH-1:0] apb_read_data_out,
    output logic                  PSLVERR,
    output logic                  PSEL1,
    output logic                  PSEL2,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  S_PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH:0]   addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    // The bus register set doubles as the latched request for the transfer in flight.
    typedef struct packed {
        logic                  psel1;
        logic                  psel2;
        logic                  penable;
        logic [ADDR_WIDTH-1:0] paddr;
        logic                  pwrite;
        logic [DATA_WIDTH-1:0] pwdata;
    } bus_t;

    state_t                state, state_d;
    bus_t                  bus_q, bus_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    req_t                  req_in;
    logic                  accept;
    logic                  timed_out;

    always_comb begin
        req_in.rw    = READ_WRITE;
        req_in.addr  = READ_WRITE ? apb_write_paddr : apb_read_paddr;
        req_in.wdata = apb_write_data;
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;

    // A PREADY arriving on the final wait cycle wins over the local timeout.
    assign timed_out = (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST);

    always_comb begin
        wait_cnt_d = wait_cnt;
        if (state == SETUP)
            wait_cnt_d = '0;
        else if (state == ACCESS && !PREADY)
            wait_cnt_d = wait_cnt + 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) wait_cnt <= '0;
        else          wait_cnt <= wait_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timed_out          = 1'b0;
`endif

    always_comb begin
        state_d = state;
        bus_d   = bus_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) accept = 1'b1;
            end
            SETUP: begin
                state_d       = ACCESS;
                bus_d.penable = 1'b1;
            end
            ACCESS: begin
                if (PREADY || timed_out) begin
                    err_d = PREADY ? S_PSLVERR : 1'b1;
                    if (PREADY && !bus_q.pwrite) rdata_d = PRDATA;
                    if (transfer) begin
                        accept = 1'b1;
                    end else begin
                        state_d       = IDLE;
                        bus_d.psel1   = 1'b0;
                        bus_d.psel2   = 1'b0;
                        bus_d.penable = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d       = SETUP;
            bus_d.psel1   = !req_in.addr[ADDR_WIDTH];
            bus_d.psel2   = req_in.addr[ADDR_WIDTH];
            bus_d.penable = 1'b0;
            bus_d.paddr   = req_in.addr[ADDR_WIDTH-1:0];
            bus_d.pwrite  = req_in.rw;
            bus_d.pwdata  = req_in.rw ? req_in.wdata : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            bus_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            bus_q   <= bus_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign PSEL1             = bus_q.psel1;
    assign PSEL2             = bus_q.psel2;
    assign PENABLE           = bus_q.penable;
    assign PADDR             = bus_q.paddr;
    assign PWRITE            = bus_q.pwrite;
    assign PWDATA            = bus_q.pwdata;
    assign apb_read_data_out = rdata_q;
    assign PSLVERR           = err_q;

endmodule
